hazard_unit_mc: RTL and testbench

Parametrised hazard unit for the 5-stage pipelined RISC-V core, the successor to the current purely combinational hazard unit. It keeps forwarding, load-use stalling and branch flushing, and adds three things: a multi-cycle multiply/divide hold in Execute, a data-memory wait stall, and saturating stall/flush performance counters. It is driven by the data path and control path, and its stall/flush outputs feed the F/D/E/M/W pipeline registers.

---
 rtl/hazard_unit_mc.sv | 153 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall, branch
// flush, multi-cycle MDU hold, data-memory wait stall and saturating
// stall/flush performance counters.
module hazard_unit_mc #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [REG_AW-1:0] i_Rs1D,
  input  logic [REG_AW-1:0] i_Rs2D,
  input  logic [REG_AW-1:0] i_Rs1E,
  input  logic [REG_AW-1:0] i_Rs2E,
  input  logic [REG_AW-1:0] i_RdE,
  input  logic [REG_AW-1:0] i_RdM,
  input  logic [REG_AW-1:0] i_RdW,
  input  logic              i_PCSrcE,
  input  logic              i_ResultSrcE_0,
  input  logic              i_RegWriteM,
  input  logic              i_RegWriteW,
  input  logic              i_MduStartE,
  input  logic              i_MemReqM,
  input  logic              i_MemReadyM,
  input  logic              i_CntClr,
  output logic              o_StallF,
  output logic              o_StallD,
  output logic              o_StallE,
  output logic              o_StallM,
  output logic              o_FlushD,
  output logic              o_FlushE,
  output logic              o_FlushM,
  output logic              o_FlushW,
  output logic [1:0]        o_ForwardAE,
  output logic [1:0]        o_ForwardBE,
  output logic              o_MduBusy,
  output logic [CNT_W-1:0]  o_StallCount,
  output logic [CNT_W-1:0]  o_FlushCount
);

  localparam int unsigned CW = $clog2(MDU_LATENCY);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(MDU_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mem_wait;
  logic          load_use;
  logic          mdu_hold;
  logic          pc_flush;

  // Forwarding select: M wins over W, x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && rs == rd_m && we_m)      sel = 2'b10;
    else if (rs != '0 && rs == rd_w && we_w) sel = 2'b01;
    return sel;
  endfunction

  // Hazard conditions and priority-ordered stall/flush decode
  always_comb begin
    mem_wait    = i_MemReqM & ~i_MemReadyM;
    load_use    = i_ResultSrcE_0 & (i_RdE != '0) &
                  ((i_Rs1D == i_RdE) | (i_Rs2D == i_RdE));
    mdu_hold    = ((state == IDLE) & i_MduStartE) |
                  ((state == BUSY) & (cnt != '0));
    pc_flush    = 1'b0;
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_StallE    = 1'b0;
    o_StallM    = 1'b0;
    o_FlushD    = 1'b0;
    o_FlushE    = 1'b0;
    o_FlushM    = 1'b0;
    o_FlushW    = 1'b0;
    o_ForwardAE = 2'b00;
    o_ForwardBE = 2'b00;
    if (!i_Reset) begin
      o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
      o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
      if (mem_wait) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_StallM = 1'b1;
        o_FlushW = 1'b1;
      end else if (mdu_hold) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_StallE = 1'b1;
        o_FlushM = 1'b1;
      end else if (i_PCSrcE) begin
        // Decode is squashed, so a pending load-use there is moot
        pc_flush = 1'b1;
        o_FlushD = 1'b1;
        o_FlushE = 1'b1;
      end else if (load_use) begin
        o_StallF = 1'b1;
        o_StallD = 1'b1;
        o_FlushE = 1'b1;
      end
    end
  end

  // MDU occupancy FSM; frozen while data memory is waiting
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!mem_wait) begin
      case (state)
        IDLE: begin
          if (i_MduStartE) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // cnt==0 is the done cycle; a start seen here is the same op
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_MduBusy = (state == BUSY);

  // Saturating performance counters, clear has priority
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_StallCount <= '0;
      o_FlushCount <= '0;
    end else if (i_CntClr) begin
      o_StallCount <= '0;
      o_FlushCount <= '0;
    end else begin
      if (o_StallF && o_StallCount != CNT_MAX) o_StallCount <= o_StallCount + CNT_W'(1);
      if (pc_flush && o_FlushCount != CNT_MAX) o_FlushCount <= o_FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with a scoreboard queue of expected values.
module tb_hazard_unit_mc;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic              pcsrce, ressrce, regwm, regww, mdustart, memreq, memready, cntclr;
  logic              stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw;
  logic [1:0]        fwda, fwdb;
  logic              busy;
  logic [CNT_W-1:0]  stallcnt, flushcnt;

  typedef struct {
    string       tag;
    bit          kind;   // 0: combinational hazard outputs, 1: registered state
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .MDU_LATENCY(4), .CNT_W(CNT_W)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Rs1D(rs1d), .i_Rs2D(rs2d), .i_Rs1E(rs1e), .i_Rs2E(rs2e),
    .i_RdE(rde), .i_RdM(rdm), .i_RdW(rdw),
    .i_PCSrcE(pcsrce), .i_ResultSrcE_0(ressrce),
    .i_RegWriteM(regwm), .i_RegWriteW(regww),
    .i_MduStartE(mdustart), .i_MemReqM(memreq), .i_MemReadyM(memready),
    .i_CntClr(cntclr),
    .o_StallF(stallf), .o_StallD(stalld), .o_StallE(stalle), .o_StallM(stallm),
    .o_FlushD(flushd), .o_FlushE(flushe), .o_FlushM(flushm), .o_FlushW(flushw),
    .o_ForwardAE(fwda), .o_ForwardBE(fwdb),
    .o_MduBusy(busy), .o_StallCount(stallcnt), .o_FlushCount(flushcnt)
  );

  task automatic clr_in();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    pcsrce = 0; ressrce = 0; regwm = 0; regww = 0; mdustart = 0;
    memreq = 0; memready = 1; cntclr = 0;
  endtask

  // Push expectations for this cycle, let outputs settle, then pop and compare
  // hv order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  task automatic step(input string tag, input logic [7:0] hv, input logic [1:0] fa,
                      input logic [1:0] fb, input logic bz, input logic [3:0] sc,
                      input logic [3:0] fc);
    exp_t e;
    logic [31:0] obs;
    q.push_back('{{tag, "_hz"}, 1'b0, {20'd0, hv, fa, fb}});
    q.push_back('{{tag, "_st"}, 1'b1, {23'd0, bz, sc, fc}});
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.kind == 1'b0)
        obs = {20'd0, stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw, fwda, fwdb};
      else
        obs = {23'd0, busy, stallcnt, flushcnt};
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    // Reset forces outputs low whatever the inputs say
    clr_in();
    rst = 1;
    rs1e = 5; rdm = 5; regwm = 1; pcsrce = 1; mdustart = 1;
    ressrce = 1; rde = 3; rs1d = 3; memreq = 1; memready = 0;
    #2;  step("reset", 8'h00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); step("reset_hold", 8'h00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); rst = 0; clr_in();
    step("idle", 8'h00, 2'b00, 2'b00, 0, 0, 0);

    // Forwarding
    @(negedge clk); rs1e = 5; rdm = 5; regwm = 1; rdw = 5; regww = 1;
    step("fwd_m", 8'h00, 2'b10, 2'b00, 0, 0, 0);
    @(negedge clk); rdm = 0; rs1e = 0;
    step("fwd_x0", 8'h00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); rs1e = 5;
    step("fwd_w_a", 8'h00, 2'b01, 2'b00, 0, 0, 0);
    @(negedge clk); clr_in(); rs2e = 7; rdw = 7; regww = 1; regwm = 0; rdm = 7;
    step("fwd_w_b", 8'h00, 2'b00, 2'b01, 0, 0, 0);

    // Load-use
    @(negedge clk); clr_in(); ressrce = 1; rde = 3; rs2d = 3;
    step("lu", 8'hC4, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); rde = 0;
    step("lu_x0", 8'h00, 2'b00, 2'b00, 0, 1, 0);

    // MDU hold, start held for the whole occupancy
    @(negedge clk); clr_in(); mdustart = 1;
    step("mdu_c1", 8'hE2, 2'b00, 2'b00, 0, 1, 0);
    @(negedge clk); step("mdu_c2", 8'hE2, 2'b00, 2'b00, 1, 2, 0);
    @(negedge clk); step("mdu_c3", 8'hE2, 2'b00, 2'b00, 1, 3, 0);
    @(negedge clk); step("mdu_done", 8'h00, 2'b00, 2'b00, 1, 4, 0);
    @(negedge clk); mdustart = 0;
    step("mdu_idle", 8'h00, 2'b00, 2'b00, 0, 4, 0);

    // Memory wait inside an MDU op (BUSY with cnt=1)
    @(negedge clk); mdustart = 1; memreq = 1; memready = 1;
    step("mw_c1", 8'hE2, 2'b00, 2'b00, 0, 4, 0);
    @(negedge clk); step("mw_c2", 8'hE2, 2'b00, 2'b00, 1, 5, 0);
    @(negedge clk); memready = 0;
    step("mw_wait1", 8'hF1, 2'b00, 2'b00, 1, 6, 0);
    @(negedge clk); step("mw_wait2", 8'hF1, 2'b00, 2'b00, 1, 7, 0);
    @(negedge clk); memready = 1;
    step("mw_c3", 8'hE2, 2'b00, 2'b00, 1, 8, 0);
    @(negedge clk); step("mw_done", 8'h00, 2'b00, 2'b00, 1, 9, 0);
    @(negedge clk); mdustart = 0; memreq = 0;
    step("mw_idle", 8'h00, 2'b00, 2'b00, 0, 9, 0);

    // Branch flush outranks load-use
    @(negedge clk); clr_in(); pcsrce = 1; ressrce = 1; rde = 3; rs1d = 3;
    step("prio", 8'h0C, 2'b00, 2'b00, 0, 9, 0);
    @(negedge clk); clr_in();
    step("prio_cnt", 8'h00, 2'b00, 2'b00, 0, 9, 1);

    // Asynchronous reset in BUSY
    @(negedge clk); mdustart = 1;
    step("rb_start", 8'hE2, 2'b00, 2'b00, 0, 9, 1);
    @(negedge clk); mdustart = 0;
    step("rb_busy", 8'hE2, 2'b00, 2'b00, 1, 10, 1);
    rst = 1; ressrce = 1; rde = 3; rs1d = 3; rs1e = 4; rdm = 4; regwm = 1;
    step("rb_async", 8'h00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); step("rb_held", 8'h00, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); rst = 0; clr_in();
    step("rb_release", 8'h00, 2'b00, 2'b00, 0, 0, 0);

    // Counter saturation and clear
    @(negedge clk); ressrce = 1; rde = 3; rs2d = 3;
    step("sat_0", 8'hC4, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      step("sat", 8'hC4, 2'b00, 2'b00, 0, (i < 15) ? 4'(i) : 4'd15, 0);
    end
    @(negedge clk); cntclr = 1;
    step("sat_20", 8'hC4, 2'b00, 2'b00, 0, 15, 0);
    @(negedge clk); cntclr = 0;
    step("clr", 8'hC4, 2'b00, 2'b00, 0, 0, 0);
    @(negedge clk); clr_in();
    step("post_clr", 8'h00, 2'b00, 2'b00, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
